ntt_bfly_pipe: RTL and testbench



---
 rtl/ntt_bfly_pipe_if.sv | 29 ++
 rtl/ntt_bfly_pipe.sv | 123 ++++++++++++
 tb/tb_ntt_bfly_pipe.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_bfly_pipe_if.sv
// Stream bundle for the NTT butterfly: input beat (a, b, twiddle, mode, tag) and output beat
// (two results plus tag), each with its own valid/ready pair.
interface ntt_bfly_pipe_if #(
  parameter int W     = 23,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [W-1:0]     in0;
  logic [W-1:0]     in1;
  logic [W-1:0]     phi;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out0;
  logic [W-1:0]     out1;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_mode, in0, in1, phi, in_tag, out_ready,
    input  in_ready, out_valid, out0, out1, out_tag
  );

  modport slave (
    input  in_valid, in_mode, in0, in1, phi, in_tag, out_ready,
    output in_ready, out_valid, out0, out1, out_tag
  );
endinterface

// File: rtl/ntt_bfly_pipe.sv
// Pipelined radix-2 CT/GS butterfly mod Q with valid/ready stall and tag sideband.
// Optional NTT_BFLY_HALVE_EN: GS results are additionally multiplied by 2^-1 mod Q.
module ntt_bfly_pipe #(
  parameter int          W     = 23,
  parameter int unsigned Q     = 8380417,
  parameter int          TAG_W = 8
) (
  input logic            clk,
  input logic            reset,
  ntt_bfly_pipe_if.slave bus
);
  localparam int            K  = $clog2(Q);
  localparam int            PW = 2*W + 4;
  localparam logic [W:0]    Q1 = (W+1)'(Q);
  localparam logic [PW-1:0] QP = PW'(Q);
  localparam logic [PW-1:0] MU = (PW'(1'b1) << (2*K)) / QP;

  function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= Q1) ? W'(s - Q1) : W'(s);
  endfunction

  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x >= y) ? (x - y) : W'({1'b0, x} + Q1 - {1'b0, y});
  endfunction

  // Barrett with k = clog2(Q): the estimate is at most two short, hence two trailing subtracts.
  function automatic logic [W-1:0] barrett(input logic [2*W-1:0] x);
    logic [PW-1:0] xp;
    logic [PW-1:0] q;
    logic [PW-1:0] r;
    xp = PW'(x);
    q  = ((xp >> (K-1)) * MU) >> (K+1);
    r  = xp - q * QP;
    r  = (r >= QP) ? (r - QP) : r;
    r  = (r >= QP) ? (r - QP) : r;
    return W'(r);
  endfunction

`ifdef NTT_BFLY_HALVE_EN
  function automatic logic [W-1:0] halve(input logic [W-1:0] v);
    return v[0] ? W'(({1'b0, v} + Q1) >> 1'b1) : (v >> 1'b1);
  endfunction
`endif

  logic             stall_s;
  logic             adv_s;
  logic             v0_r, m0_r, v1_r, m1_r, v2_r, m2_r, v3_r, m3_r;
  logic [W-1:0]     a0_r, b0_r, w0_r;
  logic [W-1:0]     x1_r, y1_r, w1_r;
  logic [W-1:0]     x2_r;
  logic [2*W-1:0]   p2_r;
  logic [W-1:0]     x3_r, r3_r;
  logic [TAG_W-1:0] t0_r, t1_r, t2_r, t3_r;
  logic             out_valid_r;
  logic [W-1:0]     out0_r, out1_r;
  logic [TAG_W-1:0] out_tag_r;
  logic [W-1:0]     x1_s, y1_s, o0_s, o1_s;

  assign stall_s       = out_valid_r & ~bus.out_ready;
  assign adv_s         = ~stall_s;
  assign bus.in_ready  = adv_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out0      = out0_r;
  assign bus.out1      = out1_r;
  assign bus.out_tag   = out_tag_r;

  // S1 pre-op: GS forms a+b and a-b ahead of the multiplier, CT passes a and b through.
  always_comb begin
    x1_s = a0_r;
    y1_s = b0_r;
    if (m0_r) begin
      x1_s = add_mod(a0_r, b0_r);
      y1_s = sub_mod(a0_r, b0_r);
    end else begin
      x1_s = a0_r;
      y1_s = b0_r;
    end
  end

  // S4 post-op: CT add/sub of the reduced product, GS forwards (optionally halved).
  always_comb begin
    o0_s = x3_r;
    o1_s = r3_r;
    if (m3_r) begin
`ifdef NTT_BFLY_HALVE_EN
      o0_s = halve(x3_r);
      o1_s = halve(r3_r);
`else
      o0_s = x3_r;
      o1_s = r3_r;
`endif
    end else begin
      o0_s = add_mod(x3_r, r3_r);
      o1_s = sub_mod(x3_r, r3_r);
    end
  end

  // Whole pipeline shifts together; a stall freezes every rank, bubbles included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0_r <= 1'b0; m0_r <= 1'b0; a0_r <= {W{1'b0}}; b0_r <= {W{1'b0}};
      w0_r <= {W{1'b0}}; t0_r <= {TAG_W{1'b0}};
      v1_r <= 1'b0; m1_r <= 1'b0; x1_r <= {W{1'b0}}; y1_r <= {W{1'b0}};
      w1_r <= {W{1'b0}}; t1_r <= {TAG_W{1'b0}};
      v2_r <= 1'b0; m2_r <= 1'b0; x2_r <= {W{1'b0}}; p2_r <= {(2*W){1'b0}};
      t2_r <= {TAG_W{1'b0}};
      v3_r <= 1'b0; m3_r <= 1'b0; x3_r <= {W{1'b0}}; r3_r <= {W{1'b0}};
      t3_r <= {TAG_W{1'b0}};
      out_valid_r <= 1'b0; out0_r <= {W{1'b0}}; out1_r <= {W{1'b0}};
      out_tag_r <= {TAG_W{1'b0}};
    end else if (adv_s) begin
      v0_r <= bus.in_valid; m0_r <= bus.in_mode; a0_r <= bus.in0; b0_r <= bus.in1;
      w0_r <= bus.phi; t0_r <= bus.in_tag;
      v1_r <= v0_r; m1_r <= m0_r; x1_r <= x1_s; y1_r <= y1_s; w1_r <= w0_r; t1_r <= t0_r;
      v2_r <= v1_r; m2_r <= m1_r; x2_r <= x1_r; t2_r <= t1_r;
      p2_r <= (2*W)'(y1_r) * (2*W)'(w1_r);
      v3_r <= v2_r; m3_r <= m2_r; x3_r <= x2_r; r3_r <= barrett(p2_r); t3_r <= t2_r;
      out_valid_r <= v3_r; out0_r <= o0_s; out1_r <= o1_s; out_tag_r <= t3_r;
    end
  end
endmodule

// File: tb/tb_ntt_bfly_pipe.sv
// Scoreboard bench for ntt_bfly_pipe: reference model pushes expected beats, a monitor pops them.
module tb_ntt_bfly_pipe;
  localparam int     W     = 23;
  localparam int     TAG_W = 8;
  localparam longint QL    = 64'd8380417;

  typedef struct {
    logic [W-1:0]     o0;
    logic [W-1:0]     o1;
    logic [TAG_W-1:0] tag;
    bit               lat;
    int               acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  logic [W-1:0]     bp_a[10], bp_b[10], bp_w[10];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ntt_bfly_pipe_if #(.W(W), .TAG_W(TAG_W)) bus();

  ntt_bfly_pipe #(.W(W), .Q(8380417), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic longint mulm(input longint x, input longint y);
    return (x * y) % QL;
  endfunction

  function automatic longint halve_ref(input longint v);
`ifdef NTT_BFLY_HALVE_EN
    return mulm(v, (QL + 64'd1) / 64'd2);
`else
    return v;
`endif
  endfunction

  function automatic exp_t mk(input longint e0, input longint e1, input logic [TAG_W-1:0] tag,
                              input bit lat);
    exp_t e;
    e.o0 = W'(e0); e.o1 = W'(e1); e.tag = tag; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  function automatic exp_t model(input bit mode, input longint a, input longint b, input longint w,
                                 input logic [TAG_W-1:0] tag, input bit lat);
    longint p;
    if (!mode) begin
      p = mulm(b, w);
      return mk((a + p) % QL, (a - p + QL) % QL, tag, lat);
    end else begin
      return mk(halve_ref((a + b) % QL), halve_ref(mulm((a - b + QL) % QL, w)), tag, lat);
    end
  endfunction

  task automatic set_in(input bit mode, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] w, input logic [TAG_W-1:0] tag);
    bus.in_valid = 1'b1; bus.in_mode = mode; bus.in0 = a; bus.in1 = b; bus.phi = w;
    bus.in_tag = tag;
  endtask

  task automatic send(input bit mode, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] w, input logic [TAG_W-1:0] tag, input exp_t e);
    int k;
    @(negedge clk);
    bus.out_ready = 1'b1;
    set_in(mode, a, b, w, tag);
    #1;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk); #1; k++;
    end
    if (!bus.in_ready) chk("accept_timeout", 0, 1);
    else begin
      e.acc = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_empty", longint'(sb.size()), 0);
  endtask

  // Monitor: compares accepted beats to the scoreboard head, and stalled outputs to the same head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && bus.out_valid) begin
        if (sb.size() == 0) chk("unexpected_out", 1, 0);
        else if (!bus.out_ready) begin
          chk("stall_out0", longint'(bus.out0), longint'(sb[0].o0));
          chk("stall_out1", longint'(bus.out1), longint'(sb[0].o1));
          chk("stall_tag", longint'(bus.out_tag), longint'(sb[0].tag));
        end else begin
          mon_e = sb.pop_front();
          chk("out0", longint'(bus.out0), longint'(mon_e.o0));
          chk("out1", longint'(bus.out1), longint'(mon_e.o1));
          chk("out_tag", longint'(bus.out_tag), longint'(mon_e.tag));
          if (mon_e.lat) chk("latency", longint'(cyc - mon_e.acc), 4);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] a, b, w;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in0 = '0; bus.in1 = '0; bus.phi = '0;
    bus.in_tag = '0; bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out0", longint'(bus.out0), 0);
    chk("rst_out1", longint'(bus.out1), 0);
    chk("rst_out_tag", longint'(bus.out_tag), 0);
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("idle_out_valid", longint'(bus.out_valid), 0);
    end

    // CT basics including the all-(Q-1) corner
    send(1'b0, 23'd1, 23'd3, 23'd1, 8'h11, mk(4, 8380415, 8'h11, 1'b1));
    send(1'b0, 23'd8380416, 23'd8380416, 23'd8380416, 8'h12, mk(0, 8380415, 8'h12, 1'b1));
    idle(1);
    drain();

`ifdef NTT_BFLY_HALVE_EN
    send(1'b1, 23'd1, 23'd3, 23'd2, 8'h21, mk(2, 8380415, 8'h21, 1'b1));
`else
    send(1'b1, 23'd1, 23'd3, 23'd2, 8'h21, mk(4, 8380413, 8'h21, 1'b1));
`endif
    send(1'b1, 23'd8380416, 23'd0, 23'd8380416, 8'h22,
         model(1'b1, 64'd8380416, 64'd0, 64'd8380416, 8'h22, 1'b1));
    idle(1);
    drain();

    // 64 back-to-back random beats, alternating mode
    for (int i = 0; i < 64; i++) begin
      a = W'($urandom_range(0, 8380416));
      b = W'($urandom_range(0, 8380416));
      w = W'($urandom_range(0, 8380416));
      send(i[0], a, b, w, TAG_W'(i), model(i[0], longint'(a), longint'(b), longint'(w),
                                           TAG_W'(i), 1'b1));
    end
    idle(1);
    drain();

    // Back-pressure: 3-cycle stall once the pipeline is full
    for (int i = 0; i < 10; i++) begin
      bp_a[i] = W'($urandom_range(0, 8380416));
      bp_b[i] = W'($urandom_range(0, 8380416));
      bp_w[i] = W'($urandom_range(0, 8380416));
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          bus.out_ready = 1'b0;
          set_in(i[0], bp_a[i], bp_b[i], bp_w[i], TAG_W'(8'h80 + i));
          #1;
          chk("stall_in_ready", longint'(bus.in_ready), 0);
          chk("stall_out_valid", longint'(bus.out_valid), 1);
        end
      end
      send(i[0], bp_a[i], bp_b[i], bp_w[i], TAG_W'(8'h80 + i),
           model(i[0], longint'(bp_a[i]), longint'(bp_b[i]), longint'(bp_w[i]),
                 TAG_W'(8'h80 + i), 1'b0));
    end
    idle(1);
    drain();

    // Reset while three beats are in flight, first one stalled at the output
    for (int i = 0; i < 3; i++) begin
      send(1'b0, W'(100 + i), W'(7), W'(9), TAG_W'(8'hC0 + i),
           model(1'b0, longint'(100 + i), 64'd7, 64'd9, TAG_W'(8'hC0 + i), 1'b0));
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      if (bus.out_valid) break;
    end
    chk("flush_reach_out", longint'(bus.out_valid), 1);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", longint'(bus.out_valid), 0);
    chk("midrst_out0", longint'(bus.out0), 0);
    chk("midrst_out_tag", longint'(bus.out_tag), 0);
    chk("midrst_in_ready", longint'(bus.in_ready), 1);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("post_rst_idle", longint'(bus.out_valid), 0);
    end
    send(1'b1, 23'd5, 23'd9, 23'd3, 8'hEE, model(1'b1, 64'd5, 64'd9, 64'd3, 8'hEE, 1'b1));
    idle(1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
